// File: rtl/sfx_arbiter.sv
// Sound-effect arbiter: grants one of four queued SFX requests to the shared bass
// tone generator, with optional preemption and an enable-pulse watchdog.
//
// state | meaning
// IDLE  | bass owns the tone generator; grant the highest pending request
// START | one-cycle start pulse to the selected library
// PLAY  | effect running; wait for done/cancel, watchdog, or preemption
// GAP   | bass restored; hold off new grants until the next enable pulse
module sfx_arbiter #(
  parameter int TICKBITS = 20,
  parameter int TIMEOUT  = 64,
  parameter int PREEMPT  = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] req,
  input  logic       cancel,
  input  logic       enable,
  input  logic       sfx_done,
  output logic       start,
  output logic [1:0] sel,
  output logic       sfx_active,
  output logic [3:0] pending,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, START, PLAY, GAP} stateT;

  localparam logic [7:0] WdLimit = 8'(TIMEOUT - 1);

  if (TICKBITS < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : gBadParam
    $error("sfx_arbiter: TICKBITS must be >= 1 and TIMEOUT within 1..255");
  end

  stateT      state;
  logic [7:0] watchdog;
  logic [1:0] topIdx;
  logic       topValid;
  logic       finish;
  logic       timeoutHit;
  logic       preempt;
  logic       grant;
  logic [3:0] grantMask;

  always_comb begin
    topIdx   = 2'd0;
    topValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pending[i]) begin
        topIdx   = 2'(i);
        topValid = 1'b1;
      end
    end
  end

  // Completion outranks the watchdog, which outranks preemption.
  assign finish     = sfx_done | cancel;
  assign timeoutHit = enable && (watchdog == WdLimit);
  assign preempt    = (PREEMPT != 0) && topValid && (topIdx > sel);
  assign grant      = ((state == IDLE) && topValid) ||
                      ((state == PLAY) && !finish && !timeoutHit && preempt);
  assign grantMask  = grant ? (4'b0001 << topIdx) : 4'b0000;

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      pending     <= 4'b0000;
      sel         <= 2'd0;
      start       <= 1'b0;
      sfx_active  <= 1'b0;
      timeout_err <= 1'b0;
      watchdog    <= 8'd0;
    end else begin
      // A request landing on the bit being granted re-queues it.
      pending     <= (pending & ~grantMask) | req;
      start       <= 1'b0;
      timeout_err <= 1'b0;
      if (grant) begin
        sel        <= topIdx;
        start      <= 1'b1;
        sfx_active <= 1'b1;
        watchdog   <= 8'd0;
        state      <= START;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          START: state <= PLAY;
          PLAY: begin
            if (finish) begin
              sfx_active <= 1'b0;
              state      <= GAP;
            end else if (timeoutHit) begin
              timeout_err <= 1'b1;
              sfx_active  <= 1'b0;
              state       <= GAP;
            end else if (enable) begin
              watchdog <= watchdog + 8'd1;
            end
          end
          GAP: if (enable) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfx_arbiter.sv
// Bench for sfx_arbiter: two instances (preemption on/off) share stimulus; a
// request-level model fills a scoreboard that a separate monitor drains.
module tb_sfx_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       clr, cancel, enable, sfxDone;
  logic [3:0] req;
  logic       startA, actA, toA, startB, actB, toB;
  logic [1:0] selA, selB;
  logic [3:0] pendA, pendB;

  always #5 clk = ~clk;

  sfx_arbiter #(.TICKBITS(20), .TIMEOUT(TO), .PREEMPT(1)) dutA (
    .clk(clk), .clr(clr), .req(req), .cancel(cancel), .enable(enable),
    .sfx_done(sfxDone), .start(startA), .sel(selA), .sfx_active(actA),
    .pending(pendA), .timeout_err(toA)
  );

  sfx_arbiter #(.TICKBITS(20), .TIMEOUT(TO), .PREEMPT(0)) dutB (
    .clk(clk), .clr(clr), .req(req), .cancel(cancel), .enable(enable),
    .sfx_done(sfxDone), .start(startB), .sel(selB), .sfx_active(actB),
    .pending(pendB), .timeout_err(toB)
  );

  typedef struct packed {
    logic [8:0] a;
    logic [8:0] b;
  } expT;

  expT scoreQ[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model, per instance: queue of requests, current owner (-1 = bass),
  // whether we are cooling down after an effect, and enable pulses counted so far.
  logic [3:0] mPend[2];
  logic [1:0] mSel[2];
  int         mOwner[2];
  int         mTicks[2];
  bit         mStart[2], mTo[2], mGap[2];

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      mPend[k] = 4'b0000; mSel[k] = 2'd0; mOwner[k] = -1; mTicks[k] = 0;
      mStart[k] = 1'b0; mTo[k] = 1'b0; mGap[k] = 1'b0;
    end
  endfunction

  function automatic void modelStep(int k, bit canPreempt, logic [3:0] r, bit c, bit e, bit d);
    int         hi = -1;
    logic [3:0] take = 4'b0000;
    bit         nStart = 1'b0;
    bit         nTo = 1'b0;
    for (int i = 0; i < 4; i++) if (mPend[k][i]) hi = i;
    if (mGap[k]) begin
      if (e) mGap[k] = 1'b0;
    end else if (mOwner[k] < 0) begin
      if (hi >= 0) begin
        take[hi] = 1'b1; mOwner[k] = hi; mSel[k] = 2'(hi); nStart = 1'b1; mTicks[k] = 0;
      end
    end else if (!mStart[k]) begin
      if (d || c) begin
        mOwner[k] = -1; mGap[k] = 1'b1;
      end else if (e && (mTicks[k] + 1 == TO)) begin
        nTo = 1'b1; mOwner[k] = -1; mGap[k] = 1'b1;
      end else if (canPreempt && hi > mOwner[k]) begin
        take[hi] = 1'b1; mOwner[k] = hi; mSel[k] = 2'(hi); nStart = 1'b1; mTicks[k] = 0;
      end else if (e) begin
        mTicks[k] = mTicks[k] + 1;
      end
    end
    mPend[k]  = (mPend[k] & ~take) | r;
    mStart[k] = nStart;
    mTo[k]    = nTo;
  endfunction

  function automatic logic [8:0] expVec(int k);
    return {mStart[k], mSel[k], (mOwner[k] >= 0), mPend[k], mTo[k]};
  endfunction

  function automatic string fmt(logic [8:0] v);
    return $sformatf("start=%0b sel=%0d active=%0b pending=%b timeout_err=%0b",
                     v[8], v[7:6], v[5], v[4:1], v[0]);
  endfunction

  task automatic cyc(input logic [3:0] r, input bit c, input bit e, input bit d, input bit rst);
    expT x;
    @(negedge clk);
    req = r; cancel = c; enable = e; sfxDone = d; clr = rst;
    if (rst) modelReset();
    else begin
      modelStep(0, 1'b1, r, c, e, d);
      modelStep(1, 1'b0, r, c, e, d);
    end
    x.a = expVec(0);
    x.b = expVec(1);
    scoreQ.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [8:0] gotA, gotB;
    expT        e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreQ.size() > 0) begin
        e    = scoreQ.pop_front();
        gotA = {startA, selA, actA, pendA, toA};
        gotB = {startB, selB, actB, pendB, toB};
        checks++;
        if (gotA !== e.a) begin
          errors++;
          $display("FAIL preemptOn t=%0t got %s expected %s", $time, fmt(gotA), fmt(e.a));
        end
        checks++;
        if (gotB !== e.b) begin
          errors++;
          $display("FAIL preemptOff t=%0t got %s expected %s", $time, fmt(gotB), fmt(e.b));
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    clr = 1'b1; req = 4'b0000; cancel = 1'b0; enable = 1'b0; sfxDone = 1'b0;
    modelReset();

    cyc(4'b0000, 0, 0, 0, 1);
    cyc(4'b0011, 0, 0, 0, 1);
    cyc(4'b0000, 1, 1, 1, 0);
    idle(1);

    // single request, done, gap released by enable
    cyc(4'b0010, 0, 0, 0, 0); idle(3);
    cyc(4'b0000, 0, 0, 1, 0); idle(2);
    cyc(4'b0000, 0, 1, 0, 0); idle(2);

    // merge, then a repeat landing on the grant edge
    cyc(4'b0010, 0, 0, 0, 0); cyc(4'b0010, 0, 0, 0, 0); idle(3);
    cyc(4'b0000, 0, 0, 1, 0); cyc(4'b0000, 0, 1, 0, 0); idle(3);
    cyc(4'b0000, 1, 0, 1, 0); cyc(4'b0000, 0, 1, 0, 0); idle(2);

    // priority
    cyc(4'b0000, 0, 0, 0, 1);
    cyc(4'b0101, 0, 0, 0, 0); idle(3);
    cyc(4'b0000, 0, 0, 1, 0); idle(1); cyc(4'b0000, 0, 1, 0, 0); idle(3);
    cyc(4'b0000, 0, 0, 1, 0); cyc(4'b0000, 0, 1, 0, 0); idle(2);

    // preemption, plus equal-index request during PLAY
    cyc(4'b0000, 0, 0, 0, 1);
    cyc(4'b0001, 0, 0, 0, 0); idle(3);
    cyc(4'b1000, 0, 0, 0, 0); idle(3);
    cyc(4'b1000, 0, 0, 0, 0); idle(1);
    cyc(4'b0000, 0, 0, 1, 0); idle(1); cyc(4'b0000, 0, 1, 0, 0); idle(3);
    cyc(4'b0000, 0, 0, 1, 0); cyc(4'b0000, 0, 1, 0, 0); idle(3);

    // watchdog
    cyc(4'b0000, 0, 0, 0, 1);
    cyc(4'b0100, 0, 0, 0, 0); idle(1);
    cyc(4'b0000, 0, 1, 0, 0);
    repeat (4) begin cyc(4'b0000, 0, 1, 0, 0); idle(1); end
    idle(1); cyc(4'b0000, 0, 1, 0, 0); idle(2);

    // done together with a visible higher-priority pending bit
    cyc(4'b0000, 0, 0, 0, 1);
    cyc(4'b0001, 0, 0, 0, 0); idle(3);
    cyc(4'b1000, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 1, 0); idle(1);
    cyc(4'b0000, 0, 1, 0, 0); idle(3);
    cyc(4'b0000, 1, 0, 0, 0); cyc(4'b0000, 0, 1, 0, 0); idle(1);

    // done on the timeout edge
    cyc(4'b0000, 0, 0, 0, 1);
    cyc(4'b0100, 0, 0, 0, 0); idle(3);
    repeat (3) begin cyc(4'b0000, 0, 1, 0, 0); idle(1); end
    cyc(4'b0000, 0, 1, 1, 0); idle(1); cyc(4'b0000, 0, 1, 0, 0); idle(1);

    // reset mid-PLAY with a request in the same cycle
    cyc(4'b0110, 0, 0, 0, 0); idle(3);
    cyc(4'b0100, 0, 0, 0, 0); idle(1);
    cyc(4'b0001, 0, 0, 0, 1); idle(2);

    repeat (3000) begin
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cyc(r, ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 11) == 0), ($urandom_range(0, 299) == 0));
    end
    idle(2);

    for (int w = 0; w < 5 && scoreQ.size() > 0; w++) @(negedge clk);
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left expected 0", scoreQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
